// File: rtl/bcd_date_counter.sv
// Calendar source for the date display: packed BCD YYYY_MMDD, advanced once every TICK_DIV clocks.
// Optional macro DATE_DOWN_EN adds a `dir` input so the date can count backwards.
module bcd_date_counter #(
    parameter int unsigned TICK_DIV  = 20000000,
    parameter logic [31:0] INIT_DATE = 32'h2024_1204
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
`ifdef DATE_DOWN_EN
    input  logic        dir,
`endif
    input  logic        load,
    input  logic [31:0] load_date,
    output logic [31:0] date,
    output logic        day_pulse,
    output logic        load_err
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic [31:0]   next_date;
    logic          load_ok;
    logic          advance;

    // Two BCD digits divisible by 4.
    function automatic logic div4(input logic [7:0] b);
        logic [3:0] o;
        o = b[3:0];
        return (!b[4] && (o == 4'd0 || o == 4'd4 || o == 4'd8)) ||
               ( b[4] && (o == 4'd2 || o == 4'd6));
    endfunction

    function automatic logic is_leap(input logic [15:0] yr);
        return (yr[7:0] != 8'h00) ? div4(yr[7:0]) : div4(yr[15:8]);
    endfunction

    // Last day of a month in BCD; 00 for an invalid month so any day fails validation.
    function automatic logic [7:0] last_day(input logic [7:0] mo, input logic leap);
        case (mo)
            8'h01, 8'h03, 8'h05, 8'h07, 8'h08, 8'h10, 8'h12: return 8'h31;
            8'h04, 8'h06, 8'h09, 8'h11:                      return 8'h30;
            8'h02:                                           return leap ? 8'h29 : 8'h28;
            default:                                         return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [15:0] bcd_inc16(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

`ifdef DATE_DOWN_EN
    function automatic logic [7:0] bcd_dec8(input logic [7:0] v);
        return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [15:0] bcd_dec16(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction
`endif

    // Next calendar date and load validation.
    always_comb begin
        logic [15:0] yr;
        logic [7:0]  mo;
        logic [7:0]  dy;
        logic        lp;
        logic [7:0]  last;
        logic [7:0]  ld_last;
        logic [31:0] up;
`ifdef DATE_DOWN_EN
        logic [31:0] down;
        logic [7:0]  pm;
`endif
        yr        = date[31:16];
        mo        = date[15:8];
        dy        = date[7:0];
        lp        = is_leap(yr);
        last      = last_day(mo, lp);
        up        = date;
        next_date = date;
        load_ok   = 1'b1;

        if (dy < last)          up = {yr, mo, bcd_inc8(dy)};
        else if (mo != 8'h12)   up = {yr, bcd_inc8(mo), 8'h01};
        else                    up = {bcd_inc16(yr), 16'h0101};

`ifdef DATE_DOWN_EN
        pm   = 8'h12;
        down = date;
        if (dy != 8'h01) begin
            down = {yr, mo, bcd_dec8(dy)};
        end else if (mo != 8'h01) begin
            pm   = bcd_dec8(mo);
            down = {yr, pm, last_day(pm, lp)};
        end else begin
            down = {bcd_dec16(yr), 16'h1231};
        end
        next_date = dir ? down : up;
`else
        next_date = up;
`endif

        for (int i = 0; i < 8; i++) begin
            if (load_date[4*i +: 4] > 4'd9) load_ok = 1'b0;
        end
        ld_last = last_day(load_date[15:8], is_leap(load_date[31:16]));
        if (load_date[7:0] == 8'h00 || load_date[7:0] > ld_last) load_ok = 1'b0;
    end

    assign advance = run && (presc == PMAX);

    // A valid load beats a same-cycle advance; an invalid one lets it through.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            date      <= INIT_DATE;
            presc     <= '0;
            day_pulse <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            day_pulse <= 1'b0;
            load_err  <= 1'b0;
            if (run) presc <= advance ? '0 : presc + PW'(1);
            if (load && load_ok) begin
                date  <= load_date;
                presc <= '0;
            end else begin
                if (load) load_err <= 1'b1;
                if (advance) begin
                    date      <= next_date;
                    day_pulse <= 1'b1;
                end
            end
        end
    end

endmodule
